// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB slave RAM model with byte-lane writes, programmable wait
// states, an address-window ERROR response and read-after-write bypass.
//
// state  | meaning
// S_IDLE | no transfer in its data phase
// S_WAIT | inserting wait states, o_hready low
// S_RESP | OKAY data phase: read data out or write lanes committed
// S_ERR1 | first ERROR cycle, o_hready low
// S_ERR2 | second ERROR cycle, o_hready high
module ahb_slave_mem #(
    parameter int          DATA_WDT  = 32,
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] ERR_BASE  = 32'hFFFF_F000,
    parameter logic [31:0] ERR_LIMIT = 32'hFFFF_FFFF,
    parameter string       INIT_FILE = ""
) (
    input  logic                i_hclk,
    input  logic                i_hreset,
    input  logic                i_hsel,
    input  logic [31:0]         i_haddr,
    input  logic [1:0]          i_htrans,
    input  logic                i_hwrite,
    input  logic [2:0]          i_hsize,
    input  logic [2:0]          i_hburst,
    input  logic [DATA_WDT-1:0] i_hwdata,
    input  logic                i_hready,
    input  logic [3:0]          i_wait,
    output logic [DATA_WDT-1:0] o_hrdata,
    output logic                o_hready,
    output logic [1:0]          o_hresp,
    output logic [15:0]         o_err_cnt
);

    localparam int NBYTES = DATA_WDT / 8;
    localparam int OFF    = $clog2(NBYTES);
    localparam int AW     = $clog2(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RESP, S_ERR1, S_ERR2} state_t;

    state_t              state, next_state;
    logic [DATA_WDT-1:0] mem [DEPTH];
    logic [AW-1:0]       idx_q, acc_idx, rd_idx;
    logic [OFF-1:0]      low_q;
    logic [2:0]          size_q;
    logic                write_q;
    logic [3:0]          cnt_q, cnt_d;
    logic                accept, acc_err, in_window, too_wide, misalign;
    logic                take, load_rd, wr_en;
    logic [NBYTES-1:0]   be;
    logic [DATA_WDT-1:0] wmerge;
    logic                unused_ok;

    assign unused_ok = ^{i_hburst, i_htrans[0]};

    assign accept    = i_hsel & i_hready & i_htrans[1];
    assign acc_idx   = i_haddr[OFF +: AW];
    assign in_window = (ERR_BASE <= ERR_LIMIT) && (i_haddr >= ERR_BASE) && (i_haddr <= ERR_LIMIT);
    assign too_wide  = int'(i_hsize) > OFF;
    assign misalign  = (i_haddr & ((32'd1 << i_hsize) - 32'd1)) != 32'd0;
    assign acc_err   = in_window | too_wide | misalign;

    assign o_hready = !(state == S_WAIT || state == S_ERR1);
    assign o_hresp  = (state == S_ERR1 || state == S_ERR2) ? 2'b01 : 2'b00;
    assign wr_en    = (state == S_RESP) && write_q;

    // Lane b is written when it lies in the same size-aligned block as the address.
    always_comb begin
        be     = '0;
        wmerge = '0;
        for (int b = 0; b < NBYTES; b++) begin
            be[b] = (((OFF'(b)) ^ low_q) >> size_q) == '0;
            wmerge[8*b +: 8] = be[b] ? i_hwdata[8*b +: 8] : mem[idx_q][8*b +: 8];
        end
    end

    always_comb begin
        next_state = state;
        cnt_d      = cnt_q;
        take       = 1'b0;
        load_rd    = 1'b0;
        rd_idx     = idx_q;
        case (state)
            S_IDLE, S_RESP, S_ERR2: begin
                next_state = S_IDLE;
                if (accept) begin
                    take = 1'b1;
                    if (acc_err) begin
                        next_state = S_ERR1;
                    end else if (i_wait != 4'd0) begin
                        next_state = S_WAIT;
                        cnt_d      = i_wait;
                    end else begin
                        next_state = S_RESP;
                        load_rd    = !i_hwrite;
                        rd_idx     = acc_idx;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    next_state = S_RESP;
                    load_rd    = !write_q;
                end
            end
            S_ERR1:  next_state = S_ERR2;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            state     <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            low_q     <= '0;
            size_q    <= '0;
            write_q   <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            state <= next_state;
            cnt_q <= cnt_d;
            if (take) begin
                idx_q   <= acc_idx;
                low_q   <= i_haddr[OFF-1:0];
                size_q  <= i_hsize;
                write_q <= i_hwrite;
            end
            if (state == S_ERR2 && o_err_cnt != 16'hFFFF)
                o_err_cnt <= o_err_cnt + 16'd1;
        end
    end

    // A read issued during the write's data phase sees the merged word.
    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset)
            o_hrdata <= '0;
        else if (load_rd)
            o_hrdata <= (wr_en && rd_idx == idx_q) ? wmerge : mem[rd_idx];
    end

    always_ff @(posedge i_hclk) begin
        if (wr_en)
            mem[idx_q] <= wmerge;
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: reset, bypass, byte lanes, wait states,
// ERROR responses, address wrap and pipelined 20-beat bursts.
module tb_ahb_slave_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready_i;
    logic [3:0]  wt;
    logic [31:0] hrdata;
    logic        hready_o;
    logic [1:0]  hresp;
    logic [15:0] err_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign hready_i = hready_o;

    ahb_slave_mem dut (
        .i_hclk    (clk),
        .i_hreset  (rst),
        .i_hsel    (hsel),
        .i_haddr   (haddr),
        .i_htrans  (htrans),
        .i_hwrite  (hwrite),
        .i_hsize   (hsize),
        .i_hburst  (hburst),
        .i_hwdata  (hwdata),
        .i_hready  (hready_i),
        .i_wait    (wt),
        .o_hrdata  (hrdata),
        .o_hready  (hready_o),
        .o_hresp   (hresp),
        .o_err_cnt (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [3:0] n);
        hsel   = 1'b1;
        haddr  = a;
        htrans = 2'd2;
        hwrite = w;
        hsize  = s;
        wt     = n;
    endtask

    task automatic idle();
        hsel   = 1'b0;
        htrans = 2'd0;
        hwrite = 1'b0;
        wt     = 4'd0;
    endtask

    function automatic logic [31:0] pat(input int k);
        return {8'hA5, 8'(k), 16'(k * 7 + 3)};
    endfunction

    initial begin
        int g;
        rst    = 1'b1;
        hburst = 3'd1;
        hwdata = 'x;
        haddr  = '0;
        hsize  = 3'd2;
        idle();
        tick();
        tick();
        chk("rst_hready", 32'(hready_o), 32'd1);
        chk("rst_hresp",  32'(hresp),    32'd0);
        chk("rst_hrdata", hrdata,        32'd0);
        chk("rst_errcnt", 32'(err_cnt),  32'd0);
        rst = 1'b0;

        // write then read the same word back-to-back
        addr(32'h10, 1'b1, 3'd2, 4'd0);
        tick();
        chk("b2b_wr_ready", 32'(hready_o), 32'd1);
        hwdata = 32'hDEADBEEF;
        addr(32'h10, 1'b0, 3'd2, 4'd0);
        tick();
        chk("b2b_rd_ready", 32'(hready_o), 32'd1);
        chk("b2b_rd_data",  hrdata,        32'hDEADBEEF);
        idle();
        hwdata = 'x;
        tick();

        // reset in the middle of a 5-wait read
        addr(32'h40, 1'b0, 3'd2, 4'd5);
        tick();
        chk("midrst_wait", 32'(hready_o), 32'd0);
        idle();
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_hready", 32'(hready_o), 32'd1);
        chk("midrst_hresp",  32'(hresp),    32'd0);
        chk("midrst_hrdata", hrdata,        32'd0);
        tick();
        rst = 1'b0;
        addr(32'h10, 1'b0, 3'd2, 4'd0);
        tick();
        chk("postrst_ready", 32'(hready_o), 32'd1);
        chk("postrst_data",  hrdata,        32'hDEADBEEF);
        idle();
        tick();

        // byte lanes with bypass, then a narrow read
        addr(32'h20, 1'b1, 3'd2, 4'd0);
        tick();
        hwdata = 32'h11223344;
        addr(32'h22, 1'b1, 3'd0, 4'd0);
        tick();
        hwdata = 32'h55AA5555;
        addr(32'h20, 1'b0, 3'd2, 4'd0);
        tick();
        chk("lane_bypass", hrdata, 32'h11AA3344);
        hwdata = 'x;
        addr(32'h23, 1'b0, 3'd0, 4'd0);
        tick();
        chk("lane_narrow_rd", hrdata, 32'h11AA3344);
        idle();
        tick();

        // three wait states
        addr(32'h10, 1'b0, 3'd2, 4'd3);
        tick();
        idle();
        chk("wait3_hold", hrdata, 32'h11AA3344);
        for (int i = 0; i < 3; i++) begin
            chk("wait3_low",   32'(hready_o), 32'd0);
            chk("wait3_hresp", 32'(hresp),    32'd0);
            tick();
        end
        chk("wait3_ready", 32'(hready_o), 32'd1);
        chk("wait3_hresp_end", 32'(hresp), 32'd0);
        chk("wait3_data",  hrdata,        32'hDEADBEEF);
        tick();
        chk("wait3_after", 32'(hready_o), 32'd1);

        // address wrap, read with one wait state
        addr(32'h0000_1000, 1'b1, 3'd2, 4'd0);
        tick();
        hwdata = 32'h0BADF00D;
        addr(32'h0, 1'b0, 3'd2, 4'd1);
        tick();
        idle();
        hwdata = 'x;
        chk("wrap_wait", 32'(hready_o), 32'd0);
        tick();
        chk("wrap_data", hrdata, 32'h0BADF00D);
        tick();

        // ERROR window read
        addr(32'hFFFF_F004, 1'b0, 3'd2, 4'd0);
        tick();
        idle();
        chk("err1_hready", 32'(hready_o), 32'd0);
        chk("err1_hresp",  32'(hresp),    32'd1);
        tick();
        chk("err2_hready", 32'(hready_o), 32'd1);
        chk("err2_hresp",  32'(hresp),    32'd1);
        tick();
        chk("err_cnt1",    32'(err_cnt),  32'd1);
        chk("err_done",    32'(hresp),    32'd0);

        // misaligned halfword write must not touch RAM
        addr(32'h1, 1'b1, 3'd1, 4'd0);
        tick();
        idle();
        hwdata = 32'hCAFEBABE;
        chk("mis_hresp", 32'(hresp), 32'd1);
        tick();
        tick();
        hwdata = 'x;
        chk("err_cnt2", 32'(err_cnt), 32'd2);
        addr(32'h0, 1'b0, 3'd2, 4'd0);
        tick();
        chk("mis_ram", hrdata, 32'h0BADF00D);
        idle();
        tick();

        // oversize write, then a read accepted in the ERR2 cycle
        addr(32'h20, 1'b1, 3'd3, 4'd0);
        tick();
        idle();
        hwdata = 32'h99999999;
        chk("wide_hresp", 32'(hresp), 32'd1);
        tick();
        addr(32'h20, 1'b0, 3'd2, 4'd0);
        tick();
        idle();
        hwdata = 'x;
        chk("wide_ram",  hrdata,       32'h11AA3344);
        chk("err_cnt3",  32'(err_cnt), 32'd3);
        chk("err2_next", 32'(hresp),   32'd0);
        tick();

        // 20-beat INCR write then read, wait states cycling 0..3
        addr(32'h100, 1'b1, 3'd2, 4'd0);
        for (int k = 0; k < 20; k++) begin
            tick();
            g = 0;
            while (hready_o !== 1'b1 && g < 16) begin
                tick();
                g++;
            end
            chk("bw_ready", 32'(hready_o), 32'd1);
            hwdata = pat(k);
            if (k < 19) begin
                addr(32'h100 + 32'(4 * (k + 1)), 1'b1, 3'd2, 4'((k + 1) % 4));
                htrans = 2'd3;
            end else begin
                idle();
            end
        end
        tick();
        hwdata = 'x;
        addr(32'h100, 1'b0, 3'd2, 4'd0);
        for (int k = 0; k < 20; k++) begin
            tick();
            g = 0;
            while (hready_o !== 1'b1 && g < 16) begin
                tick();
                g++;
            end
            chk("br_ready", 32'(hready_o), 32'd1);
            chk("br_data",  hrdata,        pat(k));
            if (k < 19) begin
                addr(32'h100 + 32'(4 * (k + 1)), 1'b0, 3'd2, 4'(k + 1) % 4'd4);
                htrans = 2'd3;
            end else begin
                idle();
            end
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
